// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction and data valid/ready ports onto
// one shared memory bus. Round-robin grant, combinational forwarding of the
// granted request, and a bus timeout that finishes hung transfers with an error.
//
// state | meaning
// IDLE  | no grant, arbitrating between pending requests
// GNT_I | instruction port owns the shared bus
// GNT_D | data port owns the shared bus
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  bus_err_o
);

  // A zero TIMEOUT_CYCLES still needs a legal one-bit counter; it just never counts.
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;   // 0 = imem served last, 1 = dmem
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               granted;
  logic               timeout;
  logic               finish;
  logic [DATA_WIDTH-1:0] bus_rdata;

  // State, round-robin pointer and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Arbitration, bus muxing, completion/timeout and next-state logic.
  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    cnt_d        = cnt_q;
    imem_ready_o = 1'b0;
    imem_rdata_o = '0;
    dmem_ready_o = 1'b0;
    dmem_rdata_o = '0;
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = '0;
    bus_err_o    = 1'b0;
    timeout      = 1'b0;
    finish       = 1'b0;
    bus_rdata    = mem_rdata_i;

    granted = (state_q != IDLE);
    if (granted) begin
      // A real ready in the last allowed cycle wins over the timeout.
      timeout     = (TIMEOUT_CYCLES != 0) && !mem_ready_i && (cnt_q == CNT_W'(TMO_LAST));
      finish      = mem_ready_i || timeout;
      bus_rdata   = timeout ? ERR_DATA : mem_rdata_i;
      mem_valid_o = 1'b1;
      bus_err_o   = timeout;
    end

    unique case (state_q)
      IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          state_d = last_gnt_q ? GNT_I : GNT_D;
        end else if (imem_valid_i) begin
          state_d = GNT_I;
        end else if (dmem_valid_i) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        mem_addr_o   = imem_addr_i;
        mem_wdata_o  = imem_wdata_i;
        mem_we_o     = imem_we_i;
        imem_rdata_o = bus_rdata;
        imem_ready_o = finish;
        if (finish) begin
          last_gnt_d = 1'b0;
          state_d    = dmem_valid_i ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        mem_addr_o   = dmem_addr_i;
        mem_wdata_o  = dmem_wdata_i;
        mem_we_o     = dmem_we_i;
        dmem_rdata_o = bus_rdata;
        dmem_ready_o = finish;
        if (finish) begin
          last_gnt_d = 1'b1;
          state_d    = imem_valid_i ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter holds the busy cycles of the current grant; it stops at the
    // timeout cycle because that cycle always ends the grant.
    if (!granted || finish) begin
      cnt_d = '0;
    end else if (TIMEOUT_CYCLES != 0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a transaction-level model of the
// arbiter, checked every cycle, plus literal expectations on completion records.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic        imem_ready_o;
  logic [31:0] imem_addr_i = '0;
  logic [31:0] imem_wdata_i = '0;
  logic [3:0]  imem_we_i = '0;
  logic [31:0] imem_rdata_o;
  logic        dmem_valid_i = 1'b0;
  logic        dmem_ready_o;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic [3:0]  dmem_we_i = '0;
  logic [31:0] dmem_rdata_o;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_rdata_i = '0;
  logic        bus_err_o;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
    .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .bus_err_o(bus_err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } req_t;

  typedef struct {
    int          cyc;
    int          port;   // 1 = imem, 2 = dmem
    logic [31:0] rdata;
    logic        err;
    logic        mv;
    logic [31:0] wdata;
    logic [3:0]  we;
  } done_t;

  req_t  iq[$];
  req_t  dq[$];
  done_t log_q[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   resp_lat = 2;      // responder answers in grant cycle resp_lat+1; -1 = never
  int   k = 0;
  int   first_mv = -1;
  logic i_fin_prev = 1'b0;
  logic d_fin_prev = 1'b0;

  // Model: who holds the bus, how many grant cycles have gone by, who was served last.
  int owner = 0;           // 0 none, 1 imem, 2 dmem
  int held = 0;
  int prev = 2;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic sample();
    logic [31:0] e_addr = '0, e_wd = '0, e_ird = '0, e_drd = '0, rd;
    logic [3:0]  e_we = '0;
    logic        e_mv = 1'b0, e_ir = 1'b0, e_dr = 1'b0, e_err = 1'b0;
    logic        tmo = 1'b0, fin = 1'b0;
    int          other;
    cyc++;
    if (rst_n && owner != 0) begin
      e_mv   = 1'b1;
      e_addr = (owner == 1) ? imem_addr_i  : dmem_addr_i;
      e_wd   = (owner == 1) ? imem_wdata_i : dmem_wdata_i;
      e_we   = (owner == 1) ? imem_we_i    : dmem_we_i;
      tmo    = !mem_ready_i && (held + 1 == TMO);
      fin    = mem_ready_i || tmo;
      rd     = tmo ? 32'hDEAD_BEEF : mem_rdata_i;
      if (owner == 1) begin e_ird = rd; e_ir = fin; end
      else            begin e_drd = rd; e_dr = fin; end
      e_err  = tmo;
    end
    chk("mem_valid", {31'b0, mem_valid_o}, {31'b0, e_mv});
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("mem_we", {28'b0, mem_we_o}, {28'b0, e_we});
    chk("imem_ready", {31'b0, imem_ready_o}, {31'b0, e_ir});
    chk("dmem_ready", {31'b0, dmem_ready_o}, {31'b0, e_dr});
    chk("imem_rdata", imem_rdata_o, e_ird);
    chk("dmem_rdata", dmem_rdata_o, e_drd);
    chk("bus_err", {31'b0, bus_err_o}, {31'b0, e_err});

    if (mem_valid_o && first_mv < 0) first_mv = cyc;
    if (imem_ready_o)
      log_q.push_back('{cyc, 1, imem_rdata_o, bus_err_o, mem_valid_o, mem_wdata_o, mem_we_o});
    if (dmem_ready_o)
      log_q.push_back('{cyc, 2, dmem_rdata_o, bus_err_o, mem_valid_o, mem_wdata_o, mem_we_o});
    i_fin_prev = imem_ready_o;
    d_fin_prev = dmem_ready_o;

    if (!rst_n) begin
      owner = 0; held = 0; prev = 2;
    end else if (owner == 0) begin
      held = 0;
      if (imem_valid_i && dmem_valid_i) owner = (prev == 1) ? 2 : 1;
      else if (imem_valid_i) owner = 1;
      else if (dmem_valid_i) owner = 2;
    end else if (fin) begin
      prev  = owner;
      other = 3 - owner;
      owner = ((other == 1) ? imem_valid_i : dmem_valid_i) ? other : 0;
      held  = 0;
    end else begin
      held++;
    end
  endtask

  task automatic drive();
    req_t r;
    if (i_fin_prev || !imem_valid_i) begin
      if (iq.size() > 0) begin
        r = iq.pop_front();
        imem_valid_i = 1'b1; imem_addr_i = r.addr; imem_wdata_i = r.wdata; imem_we_i = r.we;
      end else begin
        imem_valid_i = 1'b0; imem_addr_i = '0; imem_wdata_i = '0; imem_we_i = '0;
      end
    end
    if (d_fin_prev || !dmem_valid_i) begin
      if (dq.size() > 0) begin
        r = dq.pop_front();
        dmem_valid_i = 1'b1; dmem_addr_i = r.addr; dmem_wdata_i = r.wdata; dmem_we_i = r.we;
      end else begin
        dmem_valid_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_we_i = '0;
      end
    end
    #1;
    if (mem_valid_o) begin
      if (i_fin_prev || d_fin_prev) k = 0;
      k++;
      mem_ready_i = (resp_lat >= 0) && (k == resp_lat + 1);
      mem_rdata_i = mem_ready_i ? mem_data(mem_addr_o) : $urandom();
    end else begin
      k = 0;
      mem_ready_i = 1'b0;
      mem_rdata_i = $urandom();
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      step();
      done = (iq.size() == 0) && (dq.size() == 0) && !imem_valid_i && !dmem_valid_i && !mem_valid_o;
    end
    if (!done) chk("idle_budget", 32'd0, 32'd1);
  endtask

  task automatic chk_log(input string name, input int idx, input int port,
                         input logic [31:0] rdata, input logic err);
    if (log_q.size() > idx) begin
      chk({name, "_port"}, log_q[idx].port, port);
      chk({name, "_rdata"}, log_q[idx].rdata, rdata);
      chk({name, "_err"}, {31'b0, log_q[idx].err}, {31'b0, err});
    end else begin
      chk({name, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata_o, 32'd0);
    chk("rst_ready", {30'b0, imem_ready_o, dmem_ready_o}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;

    step();
    step();
    rst_n = 1'b1;
    step();

    // Single imem read.
    resp_lat = 2;
    log_q.delete();
    first_mv = -1;
    iq.push_back('{32'h100, 32'h0, 4'h0});
    step();
    t0 = cyc + 1;
    wait_idle();
    chk("t1_count", log_q.size(), 1);
    chk_log("t1", 0, 1, 32'h0000_0013, 1'b0);
    chk("t1_arb_latency", first_mv - t0, 1);
    if (log_q.size() > 0) chk("t1_done_cycle", log_q[0].cyc - t0, 3);

    // Simultaneous requests right after reset: imem first, dmem with no bubble.
    do_reset();
    log_q.delete();
    iq.push_back('{32'h200, 32'h0, 4'h0});
    dq.push_back('{32'h300, 32'h11, 4'h0});
    step();
    t0 = cyc + 1;
    wait_idle();
    chk("t2_count", log_q.size(), 2);
    chk_log("t2a", 0, 1, 32'h5A5A_0200, 1'b0);
    chk_log("t2b", 1, 2, 32'h5A5A_0300, 1'b0);
    if (log_q.size() > 1) begin
      chk("t2_first_done", log_q[0].cyc - t0, 3);
      chk("t2_back_to_back", log_q[1].cyc - log_q[0].cyc, 3);
    end

    // Continuous contention: I, D, I, D.
    log_q.delete();
    iq.push_back('{32'h400, 32'h0, 4'h0});
    iq.push_back('{32'h404, 32'h0, 4'h0});
    dq.push_back('{32'h500, 32'hAABB_CCDD, 4'b0011});
    dq.push_back('{32'h504, 32'h0102_0304, 4'b1100});
    step();
    wait_idle();
    chk("t3_count", log_q.size(), 4);
    chk_log("t3a", 0, 1, 32'h5A5A_0400, 1'b0);
    chk_log("t3b", 1, 2, 32'h5A5A_0500, 1'b0);
    chk_log("t3c", 2, 1, 32'h5A5A_0404, 1'b0);
    chk_log("t3d", 3, 2, 32'h5A5A_0504, 1'b0);
    if (log_q.size() > 3) begin
      chk("t3_store_we", {28'b0, log_q[1].we}, 32'h3);
      chk("t3_store_wdata", log_q[1].wdata, 32'hAABB_CCDD);
      chk("t3_read_we", {28'b0, log_q[0].we}, 32'h0);
      chk("t3_read_wdata", log_q[2].wdata, 32'h0);
      chk("t3_spacing", log_q[3].cyc - log_q[0].cyc, 9);
    end

    // Timeout on a hung dmem access, then a normal one.
    log_q.delete();
    resp_lat = -1;
    dq.push_back('{32'h600, 32'h0, 4'h0});
    step();
    t0 = cyc + 1;
    wait_idle();
    chk_log("t4_tmo", 0, 2, 32'hDEAD_BEEF, 1'b1);
    if (log_q.size() > 0) begin
      chk("t4_tmo_cycle", log_q[0].cyc - t0, 4);
      chk("t4_tmo_mv", {31'b0, log_q[0].mv}, 32'd1);
    end
    log_q.delete();
    resp_lat = 1;
    dq.push_back('{32'h604, 32'h0, 4'h0});
    step();
    wait_idle();
    chk_log("t4_after", 0, 2, 32'h5A5A_0604, 1'b0);

    // Ready exactly in the timeout cycle is a normal completion.
    log_q.delete();
    resp_lat = 3;
    dq.push_back('{32'h608, 32'h0, 4'h0});
    step();
    t0 = cyc + 1;
    wait_idle();
    chk_log("t5", 0, 2, 32'h5A5A_0608, 1'b0);
    if (log_q.size() > 0) chk("t5_cycle", log_q[0].cyc - t0, 4);

    // Reset in the middle of a dmem grant; pending imem goes first afterwards.
    resp_lat = -1;
    dq.push_back('{32'h700, 32'h0, 4'h0});
    step();
    step();
    iq.push_back('{32'h800, 32'h0, 4'h0});
    step();
    chk("t6_in_gnt_d", {31'b0, mem_valid_o}, 32'd1);
    chk("t6_gnt_addr", mem_addr_o, 32'h700);
    resp_lat = 1;
    do_reset();
    log_q.delete();
    wait_idle();
    chk("t6_count", log_q.size(), 2);
    chk_log("t6a", 0, 1, 32'h5A5A_0800, 1'b0);
    chk_log("t6b", 1, 2, 32'h5A5A_0700, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
